// File: rtl/seg7_pkg.sv
// seg7_pkg: 7-segment encodings {dp,g,f,e,d,c,b,a} shared by display stages
package seg7_pkg;
  typedef logic [7:0] seg7_t;
  localparam seg7_t SEG_BLANK = 8'h00;
  localparam int DP_BIT = 7;
  localparam seg7_t SEG_HEX [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex digit to segment lookup; i_hex digit in, o_seg segments out (dp clear)
module hex_to_seg7 import seg7_pkg::*; (
  input  logic [3:0] i_hex,
  output seg7_t      o_seg
);
  assign o_seg = SEG_HEX[i_hex];
endmodule

// File: rtl/hit_count_display.sv
// hit_count_display: counts hit rising edges mod 16, shows hex digit with dp flash; ports clk, rst_n, ena, hit, clear -> seg_out, count, ovf
module hit_count_display import seg7_pkg::*; #(
  parameter int FLASH_CYCLES   = 16,
  parameter bit ACTIVE_LOW_SEG = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       hit,
  input  logic       clear,
  output logic [7:0] seg_out,
  output logic [3:0] count,
  output logic       ovf
);
  if (FLASH_CYCLES < 1 || FLASH_CYCLES > 65535) begin : g_bad_flash
    $error("FLASH_CYCLES must be in 1..65535");
  end
  localparam logic [15:0] FLASH    = 16'(FLASH_CYCLES);
  localparam seg7_t       SEG_IDLE = ACTIVE_LOW_SEG ? ~SEG_BLANK : SEG_BLANK;
  logic        r_hit_q;
  logic [3:0]  r_count;
  logic [15:0] r_timer;
  logic        r_ovf;
  seg7_t       r_seg;
  logic        w_rise;
  seg7_t       w_digit;
  seg7_t       w_seg;
  hex_to_seg7 u_hex (.i_hex(r_count), .o_seg(w_digit));
  assign w_rise = hit & ~r_hit_q;
  // Segments are built from the registered count/timer, so the display trails the count by one edge.
  always_comb begin
    w_seg = w_digit;
    w_seg[DP_BIT] = |r_timer;
    w_seg = ena ? w_seg : SEG_BLANK;
    w_seg = ACTIVE_LOW_SEG ? ~w_seg : w_seg;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_q <= 1'b0;
      r_count <= '0;
      r_timer <= '0;
      r_ovf   <= 1'b0;
      r_seg   <= SEG_IDLE;
    end else begin
      r_seg <= w_seg;
      if (ena) begin
        r_hit_q <= hit;
        if (clear) begin
          r_count <= '0;
          r_timer <= '0;
          r_ovf   <= 1'b0;
        end else if (w_rise) begin
          r_count <= r_count + 4'd1;
          r_timer <= FLASH;
          r_ovf   <= r_ovf | (&r_count);
        end else if (|r_timer) begin
          r_timer <= r_timer - 16'd1;
        end
      end
    end
  end
  assign seg_out = r_seg;
  assign count   = r_count;
  assign ovf     = r_ovf;
endmodule

// File: tb/tb_hit_count_display.sv
// tb_hit_count_display: random and directed checks against a time-since-last-hit reference model
module tb_hit_count_display;
  localparam int FLASH = 4;
  logic       clk, rst_n, ena, hit, clear;
  logic [7:0] seg_out;
  logic [3:0] count;
  logic       ovf;
  int n_tests = 0, n_fail = 0, dp_cycles = 0;
  int m_k = 0, m_last = -100, m_total = 0;
  bit m_prev = 0;
  logic [7:0] m_seg = 8'h00;
  logic [6:0] hex [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  hit_count_display #(.FLASH_CYCLES(FLASH), .ACTIVE_LOW_SEG(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .hit(hit), .clear(clear),
    .seg_out(seg_out), .count(count), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  // Display on an enabled edge reflects the count so far and whether the
  // current enabled edge lies within FLASH edges after the last counted hit.
  task automatic model_step();
    if (!rst_n) begin
      m_k = 0; m_last = -100; m_total = 0; m_prev = 0; m_seg = 8'h00;
    end else if (ena) begin
      m_k++;
      m_seg = {(m_k - m_last) >= 1 && (m_k - m_last) <= FLASH, hex[m_total % 16]};
      if (clear) begin
        m_total = 0; m_last = -100;
      end else if (hit && !m_prev) begin
        m_total++; m_last = m_k;
      end
      m_prev = hit;
    end else m_seg = 8'h00;
  endtask
  always @(posedge clk or negedge rst_n) model_step();
  always @(negedge clk) begin
    chk("mon_seg", 16'(seg_out), 16'(m_seg));
    chk("mon_cnt", 16'(count), 16'(m_total % 16));
    chk("mon_ovf", 16'(ovf), 16'(m_total >= 16));
    if (seg_out[7]) dp_cycles++;
  end
  task automatic pulse();
    @(negedge clk) hit = 1;
    @(negedge clk) hit = 0;
  endtask
  task automatic do_clear();
    @(negedge clk) clear = 1;
    @(negedge clk) clear = 0;
  endtask
  initial begin
    clk = 0; rst_n = 0; ena = 1; hit = 0; clear = 0;
    repeat (2) @(negedge clk);
    chk("rst_seg", 16'(seg_out), 16'h00);
    chk("rst_cnt", 16'(count), 16'h0);
    chk("rst_ovf", 16'(ovf), 16'h0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("first_seg", 16'(seg_out), 16'h3F);
    @(negedge clk) dp_cycles = 0;
    repeat (3) begin
      pulse();
      repeat (8) @(negedge clk);
    end
    chk("three_cnt", 16'(count), 16'h3);
    chk("three_seg", 16'(seg_out), 16'h4F);
    chk("three_dp", 16'(dp_cycles), 16'd12);
    do_clear();
    @(negedge clk) hit = 1;
    @(negedge clk);
    @(negedge clk);
    chk("held_dp_seg", 16'(seg_out), 16'h86);
    repeat (8) @(negedge clk);
    hit = 0;
    repeat (2) @(negedge clk);
    chk("held_cnt", 16'(count), 16'h1);
    chk("held_seg", 16'(seg_out), 16'h06);
    do_clear();
    repeat (17) pulse();
    repeat (6) @(negedge clk);
    chk("wrap_cnt", 16'(count), 16'h1);
    chk("wrap_ovf", 16'(ovf), 16'h1);
    chk("wrap_seg", 16'(seg_out[6:0]), 16'h06);
    do_clear();
    @(negedge clk);
    chk("clr_cnt", 16'(count), 16'h0);
    chk("clr_ovf", 16'(ovf), 16'h0);
    chk("clr_seg", 16'(seg_out), 16'h3F);
    @(negedge clk) begin dp_cycles = 0; clear = 1; hit = 1; end
    @(negedge clk) clear = 0;
    repeat (3) @(negedge clk);
    hit = 0;
    repeat (6) @(negedge clk);
    chk("clrhit_cnt", 16'(count), 16'h0);
    chk("clrhit_dp", 16'(dp_cycles), 16'd0);
    dp_cycles = 0;
    pulse();
    pulse();
    repeat (8) @(negedge clk);
    chk("retrig_dp", 16'(dp_cycles), 16'd6);
    chk("retrig_cnt", 16'(count), 16'h2);
    ena = 0;
    repeat (20) @(negedge clk) begin
      hit = 1'($urandom_range(0, 1));
      clear = 1'($urandom_range(0, 1));
    end
    chk("frz_seg", 16'(seg_out), 16'h00);
    chk("frz_cnt", 16'(count), 16'h2);
    hit = 0; clear = 0; ena = 1;
    @(negedge clk);
    chk("unfrz_seg", 16'(seg_out), 16'h5B);
    repeat (3000) @(negedge clk) begin
      ena = $urandom_range(0, 9) != 0;
      hit = $urandom_range(0, 2) == 0;
      clear = $urandom_range(0, 39) == 0;
    end
    @(negedge clk) begin ena = 1; hit = 0; clear = 0; end
    pulse();
    @(posedge clk); #2 rst_n = 0;
    #1;
    chk("arst_seg", 16'(seg_out), 16'h00);
    chk("arst_cnt", 16'(count), 16'h0);
    chk("arst_ovf", 16'(ovf), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("rel_seg", 16'(seg_out), 16'h3F);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
